// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS receive symbol decoder with word-alignment state machine
//
// Purpose: recovers 8-bit pixel data, c0/c1 and de from one DVI channel's 10-bit
// symbols through a 2-stage pipeline, and aligns the deserializer by requesting
// bit slips until a run of control tokens is seen.
//
// Optional feature macro: TMDS_DECODER_DISPARITY_CHECK_EN (adds disp_err port)
//
// Ports:
//   clk      in   pixel clock, rising edge
//   rst      in   synchronous active-high reset
//   din      in   [9:0] raw symbol, bit 0 first on the wire
//   dout     out  [7:0] decoded pixel byte, 0 for control tokens
//   c0, c1   out  decoded control bits, held during data periods
//   de       out  1 = data symbol, 0 = control token
//   locked   out  alignment achieved
//   bitslip  out  one-cycle deserializer slip request
//   disp_err out  one-cycle running-disparity violation (macro only)

module tmds_decoder #(
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16,
    parameter int CTRL_RUN       = 8,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic       bitslip
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    ,
    output logic       disp_err
`endif
);

    localparam logic [16:0] SEARCH_LIM = 17'(SEARCH_TIMEOUT);
    localparam logic [16:0] WAIT_LIM   = 17'(SLIP_WAIT);
    localparam logic [16:0] RUN_LIM    = 17'(CTRL_RUN);
    localparam logic [16:0] LOSS_LIM   = 17'(LOSS_TIMEOUT);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_SLIP   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    logic [9:0]  r_din_1;
    state_t      r_state;
    logic [16:0] r_run;
    logic [16:0] r_cnt;   // search timeout, slip settle wait, or loss counter by state

    logic        w_is_ctrl;
    logic [1:0]  w_ctrl;
    logic [7:0]  w_d;
    logic [7:0]  w_data;
    logic [16:0] w_run_inc;
    logic [16:0] w_cnt_inc;

    // Stage 1
    always_ff @(posedge clk) begin
        if (rst) r_din_1 <= '0;
        else     r_din_1 <= din;
    end

    always_comb begin
        w_is_ctrl = 1'b1;
        w_ctrl    = 2'b00;
        case (r_din_1)
            10'b1101010100: w_ctrl = 2'b00;
            10'b0010101011: w_ctrl = 2'b01;
            10'b0101010100: w_ctrl = 2'b10;
            10'b1010101011: w_ctrl = 2'b11;
            default:        w_is_ctrl = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        w_d       = r_din_1[9] ? ~r_din_1[7:0] : r_din_1[7:0];
        w_data    = '0;
        w_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = r_din_1[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    // Stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            c0   <= 1'b0;
            c1   <= 1'b0;
            de   <= 1'b0;
        end else if (w_is_ctrl) begin
            dout <= '0;
            c1   <= w_ctrl[1];
            c0   <= w_ctrl[0];
            de   <= 1'b0;
        end else begin
            dout <= w_data;
            de   <= 1'b1;
        end
    end

    // Counters saturate at all-ones instead of wrapping.
    assign w_run_inc = (r_run == '1) ? r_run : r_run + 17'd1;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SEARCH;
            r_run   <= '0;
            r_cnt   <= '0;
            locked  <= 1'b0;
            bitslip <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (r_state)
                S_SEARCH: begin
                    r_cnt <= w_cnt_inc;
                    r_run <= w_is_ctrl ? w_run_inc : 17'd0;
                    // A data symbol clears the run, so lock needs a token this cycle.
                    if (w_is_ctrl && (w_run_inc >= RUN_LIM)) begin
                        r_state <= S_LOCKED;
                        locked  <= 1'b1;
                        r_run   <= '0;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc >= SEARCH_LIM) begin
                        r_state <= S_SLIP;
                        bitslip <= 1'b1;
                        r_run   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SLIP: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= WAIT_LIM) begin
                        r_state <= S_SEARCH;
                        r_run   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_LOCKED: begin
                    if (w_is_ctrl) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc >= LOSS_LIM) begin
                        r_state <= S_SEARCH;
                        locked  <= 1'b0;
                        r_run   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_SEARCH;
                    locked  <= 1'b0;
                    r_run   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    logic signed [5:0] r_acc;
    logic [3:0]        w_ones;
    logic signed [6:0] w_sum;

    // ones - zeros over 10 bits is 2*ones - 10; one extra bit keeps the sum exact.
    assign w_ones = 4'($countones(r_din_1));
    assign w_sum  = $signed({r_acc[5], r_acc}) + $signed({2'b00, w_ones, 1'b0}) - 7'sd10;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            disp_err <= 1'b0;
        end else begin
            disp_err <= 1'b0;
            if (w_is_ctrl) begin
                r_acc <= '0;
            end else if ((w_sum > 7'sd16) || (w_sum < -7'sd16)) begin
                disp_err <= 1'b1;
                r_acc    <= '0;
            end else begin
                r_acc <= w_sum[5:0];
            end
        end
    end
`endif

endmodule
